// File: rtl/neotang_sdram_arbiter_pkg.sv
// Shared types and constants for the NeoTang SDRAM request arbiter.
package neotang_sdram_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                    we;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] wdata;
    logic [1:0]              be;
  } sdram_req_t;

  localparam int CLI_PROM = 0;
  localparam int CLI_CROM = 1;
  localparam int CLI_FIX  = 2;

endpackage

// File: rtl/neotang_sdram_arbiter_if.sv
// Bus bundle between loader/fetch clients, the arbiter and sdram_controller.
interface neotang_sdram_arbiter_if
  import neotang_sdram_pkg::*;
#(
  parameter int N_RD   = 3,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int DATA_W = SDRAM_DATA_W
);
  logic                   loader_busy;
  logic                   wr_req;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [1:0]             wr_be;
  logic                   wr_ack;
  logic [N_RD-1:0]        rd_req;
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD-1:0]        rd_ack;
  logic [DATA_W-1:0]      rd_data;
  logic                   ctl_req;
  logic                   ctl_we;
  logic [ADDR_W-1:0]      ctl_addr;
  logic [DATA_W-1:0]      ctl_wdata;
  logic [1:0]             ctl_be;
  logic                   ctl_ack;
  logic [DATA_W-1:0]      ctl_rdata;
  logic                   arb_busy;

  modport master (
    input  loader_busy, wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr, ctl_ack, ctl_rdata,
    output wr_ack, rd_ack, rd_data, ctl_req, ctl_we, ctl_addr, ctl_wdata, ctl_be, arb_busy
  );

  modport slave (
    output loader_busy, wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr, ctl_ack, ctl_rdata,
    input  wr_ack, rd_ack, rd_data, ctl_req, ctl_we, ctl_addr, ctl_wdata, ctl_be, arb_busy
  );

endinterface

// File: rtl/neotang_sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module neotang_rr_picker #(
  parameter int N_RD = 3,
  parameter int ID_W = 2
) (
  input  logic [N_RD-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld
);

  function automatic int wrap(input int v);
    return (v >= N_RD) ? v - N_RD : v;
  endfunction

  // Walk from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int i = N_RD - 1; i >= 0; i--) begin
      if (req[wrap(int'(ptr) + i)]) begin
        gnt_id  = ID_W'(wrap(int'(ptr) + i));
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/neotang_sdram_arbiter.sv
// Single-outstanding SDRAM port arbiter: loader writes first, then N_RD readers.
// Build option ARB_ROUND_ROBIN_EN selects round-robin read grants (else fixed priority, client 0 first).
module neotang_sdram_arbiter
  import neotang_sdram_pkg::*;
#(
  parameter int N_RD   = 3,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int DATA_W = SDRAM_DATA_W
) (
  input logic                     clk_27m,
  input logic                     reset_n,
  neotang_sdram_arbiter_if.master bus
);

  localparam int ID_W = (N_RD > 1) ? $clog2(N_RD) : 1;

  arb_state_t      state_q, state_nxt;
  logic            gnt_wr_q;
  logic [ID_W-1:0] gnt_id_q;
  logic            grant_en, grant_wr;
  logic [ID_W-1:0] rd_id;
  logic            rd_vld;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q;

  neotang_rr_picker #(.N_RD(N_RD), .ID_W(ID_W)) u_picker (
    .req     (bus.rd_req),
    .ptr     (rr_ptr_q),
    .gnt_id  (rd_id),
    .gnt_vld (rd_vld)
  );

  always_ff @(posedge clk_27m) begin
    if (!reset_n)
      rr_ptr_q <= '0;
    else if (grant_en && !grant_wr)
      rr_ptr_q <= (rd_id == ID_W'(N_RD - 1)) ? '0 : rd_id + ID_W'(1);
  end
`else
  always_comb begin
    rd_id  = '0;
    rd_vld = 1'b0;
    for (int i = N_RD - 1; i >= 0; i--) begin
      if (bus.rd_req[i]) begin
        rd_id  = ID_W'(i);
        rd_vld = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_27m) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Grants happen only in IDLE; DONE is a dead cycle so a client that drops req on its ack is not re-granted.
  always_comb begin
    state_nxt = state_q;
    grant_en  = 1'b0;
    grant_wr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_req) begin
          grant_en  = 1'b1;
          grant_wr  = 1'b1;
          state_nxt = BUSY;
        end else if (!bus.loader_busy && rd_vld) begin
          grant_en  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY:    if (bus.ctl_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_27m) begin
    if (!reset_n) begin
      gnt_wr_q      <= 1'b0;
      gnt_id_q      <= '0;
      bus.ctl_req   <= 1'b0;
      bus.ctl_we    <= 1'b0;
      bus.ctl_addr  <= '0;
      bus.ctl_wdata <= '0;
      bus.ctl_be    <= 2'b00;
      bus.wr_ack    <= 1'b0;
      bus.rd_ack    <= '0;
      bus.rd_data   <= '0;
    end else begin
      bus.wr_ack <= 1'b0;
      bus.rd_ack <= '0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            bus.ctl_req <= 1'b1;
            gnt_wr_q    <= grant_wr;
            gnt_id_q    <= grant_wr ? '0 : rd_id;
            if (grant_wr) begin
              bus.ctl_we    <= 1'b1;
              bus.ctl_addr  <= bus.wr_addr;
              bus.ctl_wdata <= bus.wr_data;
              bus.ctl_be    <= bus.wr_be;
            end else begin
              bus.ctl_we    <= 1'b0;
              bus.ctl_addr  <= bus.rd_addr[int'(rd_id) * ADDR_W +: ADDR_W];
              bus.ctl_wdata <= '0;
              bus.ctl_be    <= 2'b11;
            end
          end
        end
        BUSY: begin
          if (bus.ctl_ack) begin
            bus.ctl_req <= 1'b0;
            if (gnt_wr_q) begin
              bus.wr_ack <= 1'b1;
            end else begin
              bus.rd_ack[gnt_id_q] <= 1'b1;
              bus.rd_data          <= bus.ctl_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_neotang_sdram_arbiter.sv
// Self-checking bench for neotang_sdram_arbiter: vector table, corner sequences, controller model, scoreboard.
module tb_neotang_sdram_arbiter;
  import neotang_sdram_pkg::*;

  localparam int N_RD    = 3;
  localparam int AW      = 25;
  localparam int DW      = 16;
  localparam int ACK_DLY = 4;

  typedef struct {
    logic          we;
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    be;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    sdram_req_t    req;
    int            id;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk_27m = 1'b0;
  logic reset_n;

  neotang_sdram_arbiter_if #(.N_RD(N_RD), .ADDR_W(AW), .DATA_W(DW)) bus ();

  neotang_sdram_arbiter #(.N_RD(N_RD), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_27m (clk_27m),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #18 clk_27m = ~clk_27m;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   cur_valid = 0;
  bit   prev_req  = 0;
  bit   abort_ok  = 0;
  bit   model_en  = 1;
  bit   inj_ack   = 0;
  int   mdl_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    case (a)
      25'h0000010: return 16'h1111;
      25'h0000020: return 16'h2222;
      25'h0000030: return 16'h3333;
      25'h1FFFFFF: return 16'hBEEF;
      default:     return 16'hDEAD;
    endcase
  endfunction

  task automatic push_exp(input logic we, input int id, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [1:0] be, input logic [DW-1:0] rd);
    exp_t e;
    e.req.we    = we;
    e.req.addr  = a;
    e.req.wdata = wd;
    e.req.be    = be;
    e.id        = id;
    e.rdata     = rd;
    exp_q.push_back(e);
  endtask

  task automatic set_rd_addr(input int id, input logic [AW-1:0] a);
    bus.rd_addr[id*AW +: AW] = a;
  endtask

  // One clock: monitor/scoreboard on the falling edge, then the controller model drives ctl_ack.
  task automatic tick();
    logic ack_v;
    @(negedge clk_27m);
    if (bus.wr_ack || bus.rd_ack != '0) begin
      if (!cur_valid) begin
        chk("spurious_ack", {28'd0, bus.wr_ack, bus.rd_ack}, 32'd0);
      end else begin
        chk("wr_ack", bus.wr_ack, cur.req.we);
        chk("rd_ack", bus.rd_ack, cur.req.we ? 32'd0 : (32'd1 << cur.id));
        if (!cur.req.we) chk("rd_data", bus.rd_data, cur.rdata);
        cur_valid = 0;
      end
    end else if (cur_valid && !bus.ctl_req) begin
      if (abort_ok) chk("abort_arb_busy", bus.arb_busy, 0);
      else          chk("ctl_req_held", bus.ctl_req, 1);
      cur_valid = 0;
    end
    if (bus.ctl_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", bus.ctl_req, 0);
      end else begin
        cur       = exp_q.pop_front();
        cur_valid = 1;
        chk("ctl_we", bus.ctl_we, cur.req.we);
        chk("ctl_addr", bus.ctl_addr, cur.req.addr);
        chk("ctl_be", bus.ctl_be, cur.req.be);
        if (cur.req.we) chk("ctl_wdata", bus.ctl_wdata, cur.req.wdata);
      end
    end else if (bus.ctl_req && cur_valid) begin
      chk("ctl_addr_hold", bus.ctl_addr, cur.req.addr);
    end
    prev_req = bus.ctl_req;
    ack_v    = inj_ack;
    inj_ack  = 0;
    if (model_en && bus.ctl_req) begin
      mdl_cnt++;
      if (mdl_cnt == ACK_DLY) begin
        ack_v         = 1'b1;
        bus.ctl_rdata = mem_val(bus.ctl_addr);
      end
    end else begin
      mdl_cnt = 0;
    end
    bus.ctl_ack = ack_v;
  endtask

  task automatic run_acks(input int n, input bit hold, input int bound);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < bound) begin
      tick();
      cyc++;
      if (bus.wr_ack || bus.rd_ack != '0) begin
        got++;
        if (!hold) begin
          if (bus.wr_ack) bus.wr_req = 1'b0;
          bus.rd_req = bus.rd_req & ~bus.rd_ack;
        end
      end
    end
    chk("ack_count", got, n);
  endtask

  task automatic apply_vec(input vec_t v);
    push_exp(v.we, v.id, v.addr, v.wdata, v.be, v.rdata);
    if (v.we) begin
      bus.wr_addr = v.addr;
      bus.wr_data = v.wdata;
      bus.wr_be   = v.be;
      bus.wr_req  = 1'b1;
    end else begin
      set_rd_addr(v.id, v.addr);
      bus.rd_req[v.id] = 1'b1;
    end
    tick();
    chk("grant_latency", bus.ctl_req, 1);
    run_acks(1, 0, 100);
    tick();
    chk("idle_after_done", bus.arb_busy, 0);
  endtask

  initial begin
    vec_t vecs[6];
    bit   seen;
    vecs[0] = '{1'b1, 0,        25'h0000100, 16'hA55A, 2'b01, 16'h0000};
    vecs[1] = '{1'b1, 0,        25'h1FFFFFF, 16'h5AA5, 2'b10, 16'h0000};
    vecs[2] = '{1'b0, CLI_PROM, 25'h0000010, 16'h0000, 2'b11, 16'h1111};
    vecs[3] = '{1'b0, CLI_CROM, 25'h0000020, 16'h0000, 2'b11, 16'h2222};
    vecs[4] = '{1'b0, CLI_FIX,  25'h0000030, 16'h0000, 2'b11, 16'h3333};
    vecs[5] = '{1'b0, CLI_FIX,  25'h1FFFFFF, 16'h0000, 2'b11, 16'hBEEF};

    reset_n         = 1'b0;
    bus.loader_busy = 1'b0;
    bus.wr_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.wr_be       = '0;
    bus.rd_req      = '0;
    bus.rd_addr     = '0;
    bus.ctl_ack     = 1'b0;
    bus.ctl_rdata   = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_ctl_req", bus.ctl_req, 0);
    chk("rst_ctl_we", bus.ctl_we, 0);
    chk("rst_ctl_addr", bus.ctl_addr, 0);
    chk("rst_ctl_wdata", bus.ctl_wdata, 0);
    chk("rst_ctl_be", bus.ctl_be, 0);
    chk("rst_acks", {bus.wr_ack, bus.rd_ack}, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_arb_busy", bus.arb_busy, 0);

    // Write and all reads together: write first, then 0,1,2 as each client drops on its ack
    set_rd_addr(CLI_PROM, 25'h10);
    set_rd_addr(CLI_CROM, 25'h20);
    set_rd_addr(CLI_FIX,  25'h30);
    push_exp(1'b1, 0, 25'h200, 16'h1234, 2'b11, 16'h0);
    push_exp(1'b0, CLI_PROM, 25'h10, 16'h0, 2'b11, 16'h1111);
    push_exp(1'b0, CLI_CROM, 25'h20, 16'h0, 2'b11, 16'h2222);
    push_exp(1'b0, CLI_FIX,  25'h30, 16'h0, 2'b11, 16'h3333);
    bus.wr_addr = 25'h200;
    bus.wr_data = 16'h1234;
    bus.wr_be   = 2'b11;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 3'b111;
    run_acks(4, 0, 300);
    tick();

    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

    // Fairness with clients 0 and 2 held continuously
    set_rd_addr(CLI_PROM, 25'h10);
    set_rd_addr(CLI_FIX,  25'h30);
    for (int k = 0; k < 20; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (k % 2 == 1) push_exp(1'b0, CLI_FIX, 25'h30, 16'h0, 2'b11, 16'h3333);
      else            push_exp(1'b0, CLI_PROM, 25'h10, 16'h0, 2'b11, 16'h1111);
`else
      push_exp(1'b0, CLI_PROM, 25'h10, 16'h0, 2'b11, 16'h1111);
`endif
    end
    bus.rd_req = 3'b101;
    run_acks(20, 1, 1000);
    bus.rd_req = '0;
    tick();
    tick();

    // loader_busy blocks reads, then release grants within two cycles
    bus.loader_busy = 1'b1;
    set_rd_addr(CLI_CROM, 25'h20);
    bus.rd_req = 3'b010;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.ctl_req) seen = 1;
    end
    chk("loader_busy_block", seen, 0);
    push_exp(1'b0, CLI_CROM, 25'h20, 16'h0, 2'b11, 16'h2222);
    bus.loader_busy = 1'b0;
    tick();
    seen = bus.ctl_req;
    if (!seen) begin
      tick();
      seen = bus.ctl_req;
    end
    chk("loader_release_grant", seen, 1);
    run_acks(1, 0, 100);
    tick();

    // loader_busy rising during a read does not disturb it
    push_exp(1'b0, CLI_PROM, 25'h10, 16'h0, 2'b11, 16'h1111);
    bus.rd_req = 3'b001;
    tick();
    bus.loader_busy = 1'b1;
    run_acks(1, 0, 100);
    bus.loader_busy = 1'b0;
    tick();

    // Requester drops req before its ack
    push_exp(1'b0, CLI_FIX, 25'h30, 16'h0, 2'b11, 16'h3333);
    bus.rd_req = 3'b100;
    tick();
    bus.rd_req = '0;
    run_acks(1, 0, 100);
    tick();

    // Reset while BUSY, then a late ctl_ack
    model_en = 0;
    push_exp(1'b0, CLI_CROM, 25'h20, 16'h0, 2'b11, 16'h2222);
    bus.rd_req = 3'b010;
    repeat (3) tick();
    chk("pre_reset_busy", bus.arb_busy, 1);
    abort_ok   = 1;
    reset_n    = 1'b0;
    bus.rd_req = '0;
    tick();
    chk("mid_rst_ctl_req", bus.ctl_req, 0);
    chk("mid_rst_arb_busy", bus.arb_busy, 0);
    chk("mid_rst_acks", {bus.wr_ack, bus.rd_ack}, 0);
    chk("mid_rst_rd_data", bus.rd_data, 0);
    reset_n  = 1'b1;
    abort_ok = 0;
    inj_ack  = 1;
    tick();
    tick();
    chk("late_ack_acks", {bus.wr_ack, bus.rd_ack}, 0);
    chk("late_ack_ctl_req", bus.ctl_req, 0);
    chk("late_ack_arb_busy", bus.arb_busy, 0);
    model_en = 1;

    // Spurious ctl_ack while IDLE, then a normal read still works
    inj_ack = 1;
    tick();
    tick();
    chk("idle_ack_acks", {bus.wr_ack, bus.rd_ack}, 0);
    chk("idle_ack_arb_busy", bus.arb_busy, 0);
    push_exp(1'b0, CLI_CROM, 25'h20, 16'h0, 2'b11, 16'h2222);
    bus.rd_req = 3'b010;
    run_acks(1, 0, 100);
    repeat (3) tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("outstanding", cur_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
